pipelined_adder: RTL



---
 rtl/pipelined_adder_if.sv | 28 ++
 rtl/pipelined_adder.sv | 126 ++++++++++++
 2 files changed

// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// Macro PADD_OVF_EN adds the registered signed-overflow flag ovf.
interface pipelined_adder_if #(
   parameter int unsigned WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ci;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             co;
`ifdef PADD_OVF_EN
   logic             ovf;

   modport master (output in_valid, a, b, ci, out_ready,
                   input  in_ready, out_valid, sum, co, ovf);
   modport slave  (input  in_valid, a, b, ci, out_ready,
                   output in_ready, out_valid, sum, co, ovf);
`else
   modport master (output in_valid, a, b, ci, out_ready,
                   input  in_ready, out_valid, sum, co);
   modport slave  (input  in_valid, a, b, ci, out_ready,
                   output in_ready, out_valid, sum, co);
`endif
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder: one CHUNK-wide carry slice per stage, valid/ready with full backpressure.
// Optional macro PADD_OVF_EN adds a registered signed-overflow output aligned with sum/co.
module pipelined_adder #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   pipelined_adder_if.slave bus
);
   localparam int unsigned CHUNK = WIDTH / STAGES;

   if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_cfg_err
      $error("pipelined_adder: need 1 <= STAGES <= WIDTH and WIDTH %% STAGES == 0");
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_st
      localparam int unsigned DONE = (k + 1) * CHUNK;
      localparam int unsigned REM  = WIDTH - DONE;

      logic             v_q;
      logic             c_q;
      logic [DONE-1:0]  s_q;
      logic             rdy;
      logic             up_v;
      logic             cin;
      logic [CHUNK-1:0] x;
      logic [CHUNK-1:0] y;
      logic [CHUNK-1:0] s_c;
      logic [CHUNK:0]   cc;
      logic [DONE-1:0]  s_d;

      // A stage can load when it is empty or its successor is loading too
      if (k == STAGES - 1) begin : g_rdy
         assign rdy = ~v_q | bus.out_ready;
      end else begin : g_rdy
         assign rdy = ~v_q | g_st[k+1].rdy;
      end

      if (k == 0) begin : g_src
         assign up_v = bus.in_valid;
         assign cin  = bus.ci;
         assign x    = bus.a[CHUNK-1:0];
         assign y    = bus.b[CHUNK-1:0];
         assign s_d  = s_c;
      end else begin : g_src
         assign up_v = g_st[k-1].v_q;
         assign cin  = g_st[k-1].c_q;
         assign x    = g_st[k-1].g_skew.a_q[CHUNK-1:0];
         assign y    = g_st[k-1].g_skew.b_q[CHUNK-1:0];
         assign s_d  = {s_c, g_st[k-1].s_q};
      end

      // Full-adder ripple across this stage's slice
      always_comb begin
         cc    = '0;
         s_c   = '0;
         cc[0] = cin;
         for (int i = 0; i < int'(CHUNK); i++) begin
            s_c[i]  = x[i] ^ y[i] ^ cc[i];
            cc[i+1] = (x[i] & y[i]) | (cc[i] & (x[i] | y[i]));
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v_q <= 1'b0;
            c_q <= 1'b0;
            s_q <= '0;
         end else if (rdy) begin
            v_q <= up_v;
            c_q <= cc[CHUNK];
            s_q <= s_d;
         end
      end

      // Operand bits not yet consumed, carried alongside the partial sum
      if (REM > 0) begin : g_skew
         logic [REM-1:0] a_q;
         logic [REM-1:0] b_q;
         logic [REM-1:0] a_d;
         logic [REM-1:0] b_d;

         if (k == 0) begin : g_d
            assign a_d = bus.a[WIDTH-1:CHUNK];
            assign b_d = bus.b[WIDTH-1:CHUNK];
         end else begin : g_d
            assign a_d = g_st[k-1].g_skew.a_q[REM+CHUNK-1:CHUNK];
            assign b_d = g_st[k-1].g_skew.b_q[REM+CHUNK-1:CHUNK];
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_q <= '0;
               b_q <= '0;
            end else if (rdy) begin
               a_q <= a_d;
               b_q <= b_d;
            end
         end
      end

`ifdef PADD_OVF_EN
      // Signed overflow = carry into MSB xor carry out of MSB
      if (k == STAGES - 1) begin : g_ovf
         logic ovf_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ovf_q <= 1'b0;
            end else if (rdy) begin
               ovf_q <= cc[CHUNK] ^ cc[CHUNK-1];
            end
         end
      end
`endif
   end

   assign bus.in_ready  = g_st[0].rdy;
   assign bus.out_valid = g_st[STAGES-1].v_q;
   assign bus.sum       = g_st[STAGES-1].s_q;
   assign bus.co        = g_st[STAGES-1].c_q;
`ifdef PADD_OVF_EN
   assign bus.ovf       = g_st[STAGES-1].g_ovf.ovf_q;
`endif

endmodule
